// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - memory-side responder for the CPU's multiplexed external bus
module cpu_bus_responder #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [7:0]  OPEN_BUS = 8'hFF,
   parameter int unsigned CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        phi,
   input  logic [7:0]  addr_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [7:0]  data_oe,
   output logic        rdy_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err
);

   // Last count value a request may sit at before it is abandoned.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_STALL,
      S_STALL_DONE,
      S_HOLD
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             r_phi_d;
   logic [7:0]       r_addr_lo;
   logic             r_rw_l;
   logic             r_is_read;
   logic [7:0]       r_rdata;
   logic [CNT_W-1:0] r_count;

   logic [7:0]       r_data_out;
   logic [7:0]       r_data_oe;
   logic             r_rdy_out;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [15:0]      r_mem_addr;
   logic [7:0]       r_mem_wdata;
   logic             r_bus_err;

   logic             w_rise;
   logic             w_fall;
   logic             w_ack;
   logic             w_timeout;
   logic             w_start;
   logic             w_finish;
   logic             w_stall_enter;
   logic             w_drive;

   assign w_rise    = phi & ~r_phi_d;
   assign w_fall    = ~phi & r_phi_d;
   // An ack only counts while a request is actually outstanding.
   assign w_ack     = mem_ack & r_mem_req;
   assign w_timeout = (r_count == LP_CNT_LAST);
   // Read data goes back to the CPU only in the high phase of a served read.
   assign w_drive   = (r_state == S_HOLD) && r_is_read && phi;

   assign data_out  = r_data_out;
   assign data_oe   = r_data_oe;
   assign rdy_out   = r_rdy_out;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign bus_err   = r_bus_err;

   // Phase history for edge detection and low-phase address/rw capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phi_d   <= 1'b0;
         r_addr_lo <= 8'h00;
         r_rw_l    <= 1'b0;
      end else begin
         r_phi_d <= phi;
         if (!phi) begin
            r_addr_lo <= addr_in;
            r_rw_l    <= data_in[0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      w_next        = r_state;
      w_start       = 1'b0;
      w_finish      = 1'b0;
      w_stall_enter = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_start = 1'b1;
               w_next  = S_REQ;
            end
         end
         S_REQ: begin
            if (w_ack || w_timeout) begin
               w_finish = 1'b1;
               // Completion coinciding with fall is still too late for
               // this bus cycle: the CPU must be stalled and repeat it.
               if (w_fall) begin
                  w_stall_enter = 1'b1;
                  w_next        = S_STALL_DONE;
               end else begin
                  w_next = S_HOLD;
               end
            end else if (w_fall) begin
               w_stall_enter = 1'b1;
               w_next        = S_STALL;
            end
         end
         S_STALL: begin
            if (w_ack || w_timeout) begin
               w_finish = 1'b1;
               w_next   = S_STALL_DONE;
            end
         end
         S_STALL_DONE: begin
            // The repeated cycle is served from the buffered result; its
            // address is trusted to match and a repeated write is dropped.
            if (w_rise) begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_fall) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Memory-side request, address/data latching and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 8'h00;
         r_is_read   <= 1'b0;
         r_rdata     <= 8'h00;
         r_bus_err   <= 1'b0;
      end else begin
         if (w_start) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {addr_in, r_addr_lo};
            r_mem_we   <= ~r_rw_l;
            r_is_read  <= r_rw_l;
            if (!r_rw_l) begin
               r_mem_wdata <= data_in;
            end
         end
         if (w_finish) begin
            r_mem_req <= 1'b0;
            // An ack wins over a timeout landing in the same cycle.
            if (w_ack) begin
               if (r_is_read) begin
                  r_rdata <= mem_rdata;
               end
            end else begin
               r_rdata   <= OPEN_BUS;
               r_bus_err <= 1'b1;
            end
         end
      end
   end

   // Wait counter: cleared at request start, saturating while waiting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_start) begin
         r_count <= '0;
      end else if ((r_state == S_REQ || r_state == S_STALL) && r_count != LP_CNT_MAX) begin
         r_count <= r_count + 1'b1;
      end
   end

   // CPU-side ready: dropped when the phase ends before completion,
   // released once the result is buffered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdy_out <= 1'b1;
      end else if (w_stall_enter) begin
         r_rdy_out <= 1'b0;
      end else if (r_state == S_STALL_DONE) begin
         r_rdy_out <= 1'b1;
      end
   end

   // Registered read-data drive toward the CPU.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data_out <= 8'h00;
         r_data_oe  <= 8'h00;
      end else begin
         if (w_drive) begin
            r_data_out <= r_rdata;
            r_data_oe  <= 8'hFF;
         end else begin
            r_data_oe  <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - directed self-checking bench for cpu_bus_responder
module tb_cpu_bus_responder;

   logic        clk;
   logic        rst_n;
   logic        phi;
   logic [7:0]  addr_in;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [7:0]  data_oe;
   logic        rdy_out;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        bus_err;

   int n_checks;
   int n_fail;

   cpu_bus_responder #(
      .TIMEOUT  (16),
      .OPEN_BUS (8'hFF),
      .CNT_W    (5)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .phi       (phi),
      .addr_in   (addr_in),
      .data_in   (data_in),
      .data_out  (data_out),
      .data_oe   (data_oe),
      .rdy_out   (rdy_out),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Low phase: address low byte and rw bit, held for n clocks.
   task automatic low_phase(input logic [7:0] a_lo, input logic rw, input int n);
      phi     = 1'b0;
      addr_in = a_lo;
      data_in = {7'b0, rw};
      tick(n);
   endtask

   // Start of high phase: address high byte and write data, one clock.
   task automatic rise(input logic [7:0] a_hi, input logic [7:0] wd);
      phi     = 1'b1;
      addr_in = a_hi;
      data_in = wd;
      tick(1);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_data_out"},  32'(data_out),  32'h00);
      check({pfx, "_data_oe"},   32'(data_oe),   32'h00);
      check({pfx, "_mem_req"},   32'(mem_req),   32'h0);
      check({pfx, "_mem_we"},    32'(mem_we),    32'h0);
      check({pfx, "_mem_addr"},  32'(mem_addr),  32'h0000);
      check({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'h00);
      check({pfx, "_rdy_out"},   32'(rdy_out),   32'h1);
      check({pfx, "_bus_err"},   32'(bus_err),   32'h0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      phi       = 1'b0;
      addr_in   = 8'h00;
      data_in   = 8'h00;
      mem_rdata = 8'h00;
      mem_ack   = 1'b0;

      tick(2);
      check_reset_values("rst");
      rst_n = 1'b1;

      // Zero-wait read at 0x1234, ack 2 clk after mem_req.
      low_phase(8'h34, 1'b1, 2);
      rise(8'h12, 8'h00);
      check("rd_req",  32'(mem_req),  32'h1);
      check("rd_addr", 32'(mem_addr), 32'h1234);
      check("rd_we",   32'(mem_we),   32'h0);
      tick(1);
      mem_ack   = 1'b1;
      mem_rdata = 8'hA5;
      tick(1);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      check("rd_req_drop", 32'(mem_req), 32'h0);
      tick(1);
      check("rd_data_out", 32'(data_out), 32'hA5);
      check("rd_data_oe",  32'(data_oe),  32'hFF);
      check("rd_rdy",      32'(rdy_out),  32'h1);
      phi = 1'b0;
      tick(1);
      check("rd_oe_off", 32'(data_oe), 32'h00);
      check("rd_rdy_end", 32'(rdy_out), 32'h1);

      // Write of 0x5A to 0x0200, ack 1 clk after mem_req.
      low_phase(8'h00, 1'b0, 2);
      rise(8'h02, 8'h5A);
      check("wr_req",   32'(mem_req),   32'h1);
      check("wr_addr",  32'(mem_addr),  32'h0200);
      check("wr_we",    32'(mem_we),    32'h1);
      check("wr_wdata", 32'(mem_wdata), 32'h5A);
      check("wr_oe0",   32'(data_oe),   32'h00);
      mem_ack = 1'b1;
      tick(1);
      mem_ack = 1'b0;
      check("wr_req_drop", 32'(mem_req), 32'h0);
      check("wr_oe1",      32'(data_oe), 32'h00);
      tick(2);
      check("wr_oe2", 32'(data_oe), 32'h00);
      phi = 1'b0;
      tick(1);
      check("wr_oe3", 32'(data_oe), 32'h00);

      // Late ack: read at 0x8000, 4-clk high phase, ack 6 clk after mem_req.
      low_phase(8'h00, 1'b1, 2);
      rise(8'h80, 8'h00);
      check("late_addr", 32'(mem_addr), 32'h8000);
      check("late_we",   32'(mem_we),   32'h0);
      tick(3);
      phi = 1'b0;
      tick(1);
      check("late_rdy_fall", 32'(rdy_out), 32'h0);
      check("late_req_hold", 32'(mem_req), 32'h1);
      tick(1);
      check("late_rdy_wait", 32'(rdy_out), 32'h0);
      mem_ack   = 1'b1;
      mem_rdata = 8'h3C;
      tick(1);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      check("late_req_drop", 32'(mem_req), 32'h0);
      tick(1);
      check("late_rdy_back", 32'(rdy_out), 32'h1);
      low_phase(8'h00, 1'b1, 1);
      rise(8'h80, 8'h00);
      check("late_no_req1", 32'(mem_req), 32'h0);
      tick(1);
      check("late_no_req2", 32'(mem_req),  32'h0);
      check("late_data",    32'(data_out), 32'h3C);
      check("late_oe",      32'(data_oe),  32'hFF);
      phi = 1'b0;
      tick(1);
      check("late_oe_off", 32'(data_oe), 32'h00);

      // Timeout: read at 0x4321 with no ack; mem_req must last exactly 16 clk.
      low_phase(8'h21, 1'b1, 2);
      rise(8'h43, 8'h00);
      check("to_req_start", 32'(mem_req), 32'h1);
      tick(15);
      check("to_req_15",  32'(mem_req), 32'h1);
      check("to_err_pre", 32'(bus_err), 32'h0);
      tick(1);
      check("to_req_16", 32'(mem_req), 32'h0);
      check("to_err",    32'(bus_err), 32'h1);
      tick(1);
      check("to_data", 32'(data_out), 32'hFF);
      check("to_oe",   32'(data_oe),  32'hFF);
      check("to_rdy",  32'(rdy_out),  32'h1);
      phi = 1'b0;
      tick(1);
      check("to_oe_off", 32'(data_oe), 32'h00);

      // Ack in the same clock as fall: read at 0x1111 returning 0xC3.
      low_phase(8'h11, 1'b1, 2);
      rise(8'h11, 8'h00);
      check("sim_req", 32'(mem_req), 32'h1);
      tick(1);
      phi       = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 8'hC3;
      tick(1);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      check("sim_rdy_low",  32'(rdy_out), 32'h0);
      check("sim_req_drop", 32'(mem_req), 32'h0);
      tick(1);
      check("sim_rdy_back", 32'(rdy_out), 32'h1);
      low_phase(8'h11, 1'b1, 1);
      rise(8'h11, 8'h00);
      check("sim_no_req", 32'(mem_req), 32'h0);
      tick(1);
      check("sim_data", 32'(data_out), 32'hC3);
      check("sim_oe",   32'(data_oe),  32'hFF);
      check("sim_err_sticky", 32'(bus_err), 32'h1);
      phi = 1'b0;
      tick(1);

      // Reset while a request is outstanding, then a stray ack.
      low_phase(8'h55, 1'b1, 2);
      rise(8'h66, 8'h00);
      check("rr_req", 32'(mem_req), 32'h1);
      rst_n = 1'b0;
      phi   = 1'b0;
      tick(1);
      check_reset_values("rr");
      rst_n     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 8'h77;
      tick(1);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      tick(1);
      check("rr_ack_req",  32'(mem_req),  32'h0);
      check("rr_ack_oe",   32'(data_oe),  32'h00);
      check("rr_ack_dout", 32'(data_out), 32'h00);
      check("rr_ack_err",  32'(bus_err),  32'h0);
      check("rr_ack_rdy",  32'(rdy_out),  32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side endpoint of the CPU's multiplexed external bus.
- Low phase of `phi`: address low byte on the address pins; `rw` on data pin 0.
- High phase of `phi`: address high byte on the address pins; write data on the data pins.
- The block demultiplexes each bus cycle into a 16-bit req/ack memory transaction, drives read data back during the high phase, and stretches slow accesses through `rdy_out`.

Parameters:
- TIMEOUT, 16: clk cycles a request may wait for `mem_ack` before it is aborted.
- OPEN_BUS, 8'hFF: read data returned on timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- phi  in  1  CPU bus phase: 0 = low phase, 1 = high phase. Each phase lasts ≥2 clk.
- addr_in  in  8  CPU address pins: A[7:0] when phi=0, A[15:8] when phi=1.
- data_in  in  8  CPU data pins: {7'b0, rw} when phi=0, write data when phi=1.
- data_out  out  8  read data driven toward the CPU.
- data_oe  out  8  all 1s while driving data_out, else all 0s.
- rdy_out  out  1  0 stalls the CPU; the CPU repeats the bus cycle.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1.
- mem_addr  out  16  transaction address; stable while mem_req=1.
- mem_wdata  out  8  write data; stable while mem_req=1.
- mem_rdata  in  8  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  single-cycle completion pulse.
- bus_err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at posedge clk), all outputs and state:
  - data_out=0, data_oe=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdy_out=1, bus_err=0.
  - internal rdata=0, timeout count=0, phi_d=0, state=IDLE.
  - Reset mid-transaction drops mem_req in the next cycle; a later mem_ack is ignored.
- Edge detection: phi_d registers phi every clk.
  - rise = phi & ~phi_d; fall = ~phi & phi_d.
- Low-phase capture (any state, phi=0): every clk, addr_lo <= addr_in and rw_l <= data_in[0]. The last sample before rise wins.
- States:
  - IDLE:
    - On rise: mem_addr <= {addr_in, addr_lo}; mem_we <= ~rw_l; mem_wdata <= data_in (only when rw_l=0).
    - Then mem_req <= 1, count <= 0, go to REQ.
    - mem_req is first visible 1 clk after the rise sample.
  - REQ (mem_req=1, count increments each clk):
    - mem_ack: mem_req <= 0; on a read, rdata <= mem_rdata; go to HOLD.
    - count == TIMEOUT-1 without ack: mem_req <= 0, rdata <= OPEN_BUS, bus_err <= 1, go to HOLD.
    - fall while still waiting: rdy_out <= 0, go to STALL.
    - ack and fall in the same cycle: ack is accepted, the cycle counts as late, go to STALL_DONE.
  - HOLD:
    - When the cycle is a read and phi=1: data_out=rdata, data_oe=8'hFF (registered; asserted the clk after entry).
    - On fall: data_oe <= 0, go to IDLE.
  - STALL (rdy_out=0): keep waiting for ack or timeout under the same rules as REQ, then go to STALL_DONE.
  - STALL_DONE:
    - rdy_out <= 1.
    - The next rise is the CPU's repeated cycle. It is served from rdata with no new memory request; its address is not compared. Go to HOLD.
    - Write cycles complete in memory during STALL; the repeated write is discarded.
- Writes never assert data_oe.
- data_oe=1 only when phi=1, state=HOLD and the cycle is a read. It must drop within 1 clk of fall.
- The timeout counter saturates and never wraps.
- bus_err is also set by a timeout that occurs in STALL.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Zero-wait read:
  - Stimulus: phi=0 with addr_in=8'h34, data_in=8'h01; phi=1 with addr_in=8'h12; mem_ack 2 clk after mem_req with mem_rdata=8'hA5.
  - Required: mem_addr=16'h1234, mem_we=0; data_out=8'hA5 with data_oe=8'hFF before fall and 8'h00 1 clk after fall; rdy_out stays 1.
- Write:
  - Stimulus: phi=0 with addr_in=8'h00, data_in=8'h00; phi=1 with addr_in=8'h02, data_in=8'h5A; ack 1 clk after mem_req.
  - Required: mem_addr=16'h0200, mem_we=1, mem_wdata=8'h5A; data_oe stays 8'h00 throughout.
- Late ack:
  - Stimulus: read at 16'h8000; high phase is 4 clk; ack arrives 6 clk after mem_req with mem_rdata=8'h3C.
  - Required: rdy_out=0 from fall until ack; rdy_out=1 afterwards; the repeated cycle drives 8'h3C with no second mem_req.
- Timeout:
  - Stimulus: read with no ack, TIMEOUT=16.
  - Required: mem_req deasserts after 16 clk; bus_err=1; data_out=8'hFF on the served cycle.
- Reset mid-REQ:
  - Stimulus: rst_n=0 for 1 clk while mem_req=1.
  - Required: all outputs at their reset values next clk; a following mem_ack causes no change.
- Simultaneous ack and fall:
  - Stimulus: mem_ack in the same clk as fall.
  - Required: rdy_out=0 for ≥1 clk, then 1; the repeated cycle returns the acked data.
